// File: rtl/regex_memory_arbiter_if.sv
// Fetch-side bundle between the CPU memory ports, the arbiter and the shared instruction memory.
// The master side drives requests and memory data; the slave side is the arbiter.
interface regex_memory_arbiter_if #(
    parameter int unsigned N_CPU             = 4,
    parameter int unsigned MEMORY_WIDTH      = 20,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11
);
    logic [N_CPU-1:0]                   cpu_memory_valid;
    logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_memory_addr;
    logic [N_CPU-1:0]                   cpu_memory_ready;
    logic [MEMORY_WIDTH-1:0]            cpu_memory_data;
    logic                               mem_en;
    logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr;
    logic [MEMORY_WIDTH-1:0]            mem_data;

    modport master (
        output cpu_memory_valid, cpu_memory_addr, mem_data,
        input  cpu_memory_ready, cpu_memory_data, mem_en, mem_addr
    );

    modport slave (
        input  cpu_memory_valid, cpu_memory_addr, mem_data,
        output cpu_memory_ready, cpu_memory_data, mem_en, mem_addr
    );
endinterface

// File: rtl/regex_memory_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction memory among N_CPU regex_cpu fetch ports.
// One fetch per three cycles: GRANT (ready + mem_en), DATA (memory output forwarded), IDLE (arbitrate).
module regex_memory_arbiter #(
    parameter int unsigned N_CPU             = 4,
    parameter int unsigned MEMORY_WIDTH      = 20,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11
) (
    input logic                   clk,
    input logic                   rst,
    regex_memory_arbiter_if.slave bus
);
    localparam int unsigned ID_BITS = $clog2(N_CPU);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [ID_BITS-1:0]           last_grant;
    logic [ID_BITS-1:0]           grant_nxt;
    logic [ID_BITS-1:0]           win_id;
    logic                         win_found;
    logic [N_CPU-1:0]             eligible;
    logic [MEMORY_ADDR_WIDTH-1:0] win_addr;
    logic                         holdoff;
    logic [MEMORY_WIDTH-1:0]      data_hold;
    logic [N_CPU-1:0]             ready_q;
    logic [N_CPU-1:0]             ready_nxt;
    logic                         en_q;
    logic                         en_nxt;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_q;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_nxt;

    // Round-robin search starting after last_grant; the last winner is masked for one
    // IDLE cycle so a CPU that is slow to drop valid is not served twice.
    always_comb begin
        eligible = bus.cpu_memory_valid;
        if (holdoff) begin
            eligible[last_grant] = 1'b0;
        end
        win_found = 1'b0;
        win_id    = last_grant;
        for (int unsigned k = 1; k <= N_CPU; k++) begin
            if (!win_found && eligible[ID_BITS'((32'(last_grant) + k) % N_CPU)]) begin
                win_found = 1'b1;
                win_id    = ID_BITS'((32'(last_grant) + k) % N_CPU);
            end
        end
        win_addr = '0;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            if (win_id == ID_BITS'(i)) begin
                win_addr = bus.cpu_memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_found) state_nxt = GRANT;
            GRANT:   state_nxt = DATA;
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered grant outputs; only an IDLE win launches a fetch.
    always_comb begin
        ready_nxt = '0;
        en_nxt    = 1'b0;
        addr_nxt  = addr_q;
        grant_nxt = last_grant;
        if (state == IDLE && win_found) begin
            ready_nxt[win_id] = 1'b1;
            en_nxt            = 1'b1;
            addr_nxt          = win_addr;
            grant_nxt         = win_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= '0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            last_grant <= ID_BITS'(N_CPU - 1);
            holdoff    <= 1'b0;
            data_hold  <= '0;
        end else begin
            ready_q    <= ready_nxt;
            en_q       <= en_nxt;
            addr_q     <= addr_nxt;
            last_grant <= grant_nxt;
            holdoff    <= (state == DATA);
            if (state == DATA) begin
                data_hold <= bus.mem_data;
            end
        end
    end

    assign bus.cpu_memory_ready = ready_q;
    assign bus.mem_en           = en_q;
    assign bus.mem_addr         = addr_q;
    // Memory output passes straight through in DATA and is held afterwards.
    assign bus.cpu_memory_data  = (state == DATA) ? bus.mem_data : data_hold;
endmodule

// File: tb/tb_regex_memory_arbiter.sv
// Scoreboard bench for regex_memory_arbiter: expected grants are queued as requests are raised
// and matched against grants observed on the bus, one task per scenario.
module tb_regex_memory_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 20;
    localparam int unsigned AW = 11;

    typedef struct {
        logic [N-1:0]  ready;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    typedef struct {
        logic [N-1:0]  ready;
        logic          en;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [N-1:0]  ready_next;
        int            cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regex_memory_arbiter_if #(.N_CPU(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) bus ();

    regex_memory_arbiter #(.N_CPU(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // CPU side: req_hold is a level request; req_once drops by itself after its ready pulse.
    logic [N-1:0]  req_hold = '0;
    logic [N-1:0]  req_once = '0;
    logic [N-1:0]  served   = '0;
    logic [AW-1:0] addr_tab [N];

    assign bus.cpu_memory_valid = req_hold | (req_once & ~served);
    for (genvar i = 0; i < N; i++) begin : g_addr
        assign bus.cpu_memory_addr[i*AW +: AW] = addr_tab[i];
    end

    always @(negedge clk) served = (served | bus.cpu_memory_ready) & req_once;

    // Synchronous memory: data the cycle after an enabled edge, junk otherwise.
    logic [W-1:0] mem_junk = 20'hFFFFF;
    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 11'h05A) return 20'h4ABCD;
        return {a, 9'h000} ^ 20'h13579;
    endfunction
    always @(posedge clk) bus.mem_data <= bus.mem_en ? mem_word(bus.mem_addr) : mem_junk;

    // Monitor: capture every grant with the data seen one cycle later.
    int   cyc      = 0;
    int   en_count = 0;
    int   bad_en   = 0;
    obs_t obs_q[$];
    exp_t exp_q[$];
    obs_t pend;
    logic pend_v = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            pend_v = 1'b0;
        end else begin
            if (pend_v) begin
                pend.data       = bus.cpu_memory_data;
                pend.ready_next = bus.cpu_memory_ready;
                obs_q.push_back(pend);
                pend_v = 1'b0;
            end
            if (bus.mem_en === 1'b1) en_count++;
            if (bus.mem_en !== (bus.cpu_memory_ready != '0) || $countones(bus.cpu_memory_ready) > 1) bad_en++;
            if (bus.cpu_memory_ready != '0) begin
                pend.ready = bus.cpu_memory_ready;
                pend.en    = bus.mem_en;
                pend.addr  = bus.mem_addr;
                pend.cyc   = cyc;
                pend_v     = 1'b1;
            end
        end
    end

    function automatic void expect_grant(input int id, input logic [AW-1:0] a);
        exp_t e;
        e.ready     = '0;
        e.ready[id] = 1'b1;
        e.addr      = a;
        e.data      = mem_word(a);
        exp_q.push_back(e);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        req_hold = '0;
        req_once = '0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_obs(input int n, input int budget);
        for (int k = 0; k < budget && obs_q.size() < n; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        int base;
        #1;
        n_checks++; if (bus.cpu_memory_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", bus.cpu_memory_ready); else n_pass++;
        n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); else n_pass++;
        n_checks++; if (bus.mem_addr !== 11'h0) $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.cpu_memory_data !== 20'h0) $display("FAIL reset_data: got %h want 00000", bus.cpu_memory_data); else n_pass++;
        @(negedge clk);
        rst  = 1'b1;
        base = en_count;
        repeat (5) @(negedge clk);
        n_checks++; if (en_count - base != 0) $display("FAIL idle_no_fetch: got %0d fetches want 0", en_count - base); else n_pass++;
        n_checks++; if (bus.cpu_memory_data !== 20'h0) $display("FAIL idle_data: got %h want 00000", bus.cpu_memory_data); else n_pass++;
    endtask

    task automatic test_single_fetch();
        exp_t e;
        obs_t o;
        do_reset();
        addr_tab[1] = 11'h05A;
        expect_grant(1, 11'h05A);
        req_once[1] = 1'b1;
        wait_obs(1, 30);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.ready, o.en, o.addr, o.data, o.ready_next} !== {e.ready, 1'b1, e.addr, e.data, 4'b0})
                $display("FAIL single_grant: got rdy=%b en=%b addr=%h data=%h nxt=%b want rdy=%b en=1 addr=%h data=%h nxt=0000", o.ready, o.en, o.addr, o.data, o.ready_next, e.ready, e.addr, e.data);
            else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL single_missing: got %0d grants outstanding want 0", exp_q.size()); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.cpu_memory_data !== 20'h4ABCD) $display("FAIL single_hold: got %h want 4abcd", bus.cpu_memory_data); else n_pass++;
    endtask

    task automatic test_all_request();
        exp_t e;
        obs_t o;
        int   cycs[$];
        do_reset();
        for (int i = 0; i < N; i++) begin
            addr_tab[i] = AW'(16 * (i + 1));
            expect_grant(i, addr_tab[i]);
        end
        req_once = 4'hF;
        wait_obs(4, 60);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            cycs.push_back(o.cyc);
            n_checks++;
            if ({o.ready, o.en, o.addr, o.data, o.ready_next} !== {e.ready, 1'b1, e.addr, e.data, 4'b0})
                $display("FAIL all_grant: got rdy=%b en=%b addr=%h data=%h nxt=%b want rdy=%b en=1 addr=%h data=%h nxt=0000", o.ready, o.en, o.addr, o.data, o.ready_next, e.ready, e.addr, e.data);
            else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL all_missing: got %0d grants outstanding want 0", exp_q.size()); else n_pass++;
        for (int k = 1; k < cycs.size(); k++) begin
            n_checks++; if (cycs[k] - cycs[k-1] != 3) $display("FAIL all_spacing: got %0d cycles want 3", cycs[k] - cycs[k-1]); else n_pass++;
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        obs_t o;
        int   cycs[$];
        int   gap_want[3] = '{3, 3, 4};
        do_reset();
        addr_tab[0] = 11'h100;
        addr_tab[2] = 11'h200;
        expect_grant(0, 11'h100);
        expect_grant(2, 11'h200);
        expect_grant(0, 11'h100);
        expect_grant(0, 11'h100);
        req_hold[0] = 1'b1;
        req_once[2] = 1'b1;
        wait_obs(4, 80);
        req_hold[0] = 1'b0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            cycs.push_back(o.cyc);
            n_checks++;
            if ({o.ready, o.en, o.addr, o.data} !== {e.ready, 1'b1, e.addr, e.data})
                $display("FAIL fair_grant: got rdy=%b en=%b addr=%h data=%h want rdy=%b en=1 addr=%h data=%h", o.ready, o.en, o.addr, o.data, e.ready, e.addr, e.data);
            else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL fair_missing: got %0d grants outstanding want 0", exp_q.size()); else n_pass++;
        for (int k = 1; k < cycs.size(); k++) begin
            n_checks++; if (cycs[k] - cycs[k-1] != gap_want[k-1]) $display("FAIL fair_spacing%0d: got %0d cycles want %0d", k, cycs[k] - cycs[k-1], gap_want[k-1]); else n_pass++;
        end
    endtask

    task automatic test_holdoff();
        logic seen;
        int   base;
        int   bad0;
        // hold_cycles 2 sits inside the holdoff window, 3 is past it and counts as a new request
        for (int hold = 2; hold <= 3; hold++) begin
            do_reset();
            addr_tab[3] = 11'h333;
            base = en_count;
            bad0 = bad_en;
            req_hold[3] = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = bus.cpu_memory_ready[3];
            end
            n_checks++; if (seen !== 1'b1) $display("FAIL holdoff_timeout: got no ready[3] want ready[3]"); else n_pass++;
            repeat (hold + 1) @(negedge clk);
            req_hold[3] = 1'b0;
            repeat (12) @(negedge clk);
            n_checks++; if (en_count - base != hold - 1) $display("FAIL holdoff_fetches_h%0d: got %0d want %0d", hold, en_count - base, hold - 1); else n_pass++;
            n_checks++; if (obs_q.size() != hold - 1) $display("FAIL holdoff_grants_h%0d: got %0d want %0d", hold, obs_q.size(), hold - 1); else n_pass++;
            n_checks++; if (bad_en - bad0 != 0) $display("FAIL holdoff_spurious_h%0d: got %0d want 0", hold, bad_en - bad0); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        exp_t e;
        obs_t o;
        logic seen;
        logic zero_bad;
        int   rel;
        do_reset();
        addr_tab[1] = 11'h05A;
        req_once[1] = 1'b1;
        wait_obs(1, 30);
        repeat (2) @(negedge clk);
        n_checks++; if (bus.cpu_memory_data !== 20'h4ABCD) $display("FAIL rmid_pre_data: got %h want 4abcd", bus.cpu_memory_data); else n_pass++;
        addr_tab[2] = 11'h222;
        req_hold[2] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.cpu_memory_ready[2];
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL rmid_timeout: got no ready[2] want ready[2]"); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.cpu_memory_ready !== 4'b0) $display("FAIL rmid_ready: got %b want 0000", bus.cpu_memory_ready); else n_pass++;
        n_checks++; if (bus.mem_en !== 1'b0) $display("FAIL rmid_mem_en: got %b want 0", bus.mem_en); else n_pass++;
        n_checks++; if (bus.cpu_memory_data !== 20'h0) $display("FAIL rmid_data: got %h want 00000", bus.cpu_memory_data); else n_pass++;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        rel      = cyc;
        rst      = 1'b1;
        req_once = 4'b0100;
        req_hold = '0;
        expect_grant(2, 11'h222);
        zero_bad = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.cpu_memory_ready[2];
            if (bus.cpu_memory_data !== 20'h0) zero_bad = 1'b1;
        end
        n_checks++; if (zero_bad !== 1'b0) $display("FAIL rmid_data_zero: got nonzero data before DATA want 00000"); else n_pass++;
        wait_obs(1, 5);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.ready, o.en, o.addr, o.data} !== {e.ready, 1'b1, e.addr, e.data})
                $display("FAIL rmid_grant: got rdy=%b en=%b addr=%h data=%h want rdy=%b en=1 addr=%h data=%h", o.ready, o.en, o.addr, o.data, e.ready, e.addr, e.data);
            else n_pass++;
            n_checks++; if (o.cyc != rel + 1) $display("FAIL rmid_latency: got %0d cycles want 1", o.cyc - rel); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rmid_missing: got %0d grants outstanding want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        obs_t o;
        do_reset();
        addr_tab[0] = 11'h0A0;
        addr_tab[3] = 11'h3A0;
        expect_grant(0, 11'h0A0);
        expect_grant(3, 11'h3A0);
        req_once = 4'b1001;
        wait_obs(2, 40);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if ({o.ready, o.en, o.addr, o.data} !== {e.ready, 1'b1, e.addr, e.data})
                $display("FAIL wrap_grant: got rdy=%b en=%b addr=%h data=%h want rdy=%b en=1 addr=%h data=%h", o.ready, o.en, o.addr, o.data, e.ready, e.addr, e.data);
            else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL wrap_missing: got %0d grants outstanding want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) addr_tab[i] = '0;
        test_reset();
        test_single_fetch();
        test_all_request();
        test_fairness();
        test_holdoff();
        test_reset_mid_fetch();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1);
    end
endmodule

// File: doc/regex_memory_arbiter.md
# regex_memory_arbiter

Shares one synchronous instruction memory among `N_CPU` `regex_cpu` instances. It sits directly upstream of each CPU's memory port. It takes each CPU's `memory_valid`/`memory_addr` request, grants one requester at a time in round-robin order, and pulses that CPU's `memory_ready`. It then returns the fetched instruction word on a shared `memory_data` bus, using the same timing the CPU expects from its memory port.

## Interface
- `N_CPU`, 4: number of requesting CPUs, ≥2.
- `MEMORY_WIDTH`, 20: instruction word width.
- `MEMORY_ADDR_WIDTH`, 11: instruction memory address width.
- `ID_BITS`, `$clog2(N_CPU)`: grant index width (derived).

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `cpu_memory_valid`  in  N_CPU: per-CPU fetch request, held by the CPU until served.
- `cpu_memory_addr`  in  N_CPU*MEMORY_ADDR_WIDTH: per-CPU fetch address; slice i belongs to CPU i.
- `cpu_memory_ready`  out  N_CPU: one-hot grant pulse, one cycle wide, registered.
- `cpu_memory_data`  out  MEMORY_WIDTH: instruction word, broadcast to all CPUs.
- `mem_en`  out  1: memory read enable, registered.
- `mem_addr`  out  MEMORY_ADDR_WIDTH: memory read address, registered.
- `mem_data`  in  MEMORY_WIDTH: memory read data. Valid the cycle after the edge that samples `mem_en=1`.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - GRANT: `cpu_memory_ready[g]=1`, `mem_en=1`, `mem_addr=addr[g]`.
  - DATA: memory output forwarded.
- Transitions: IDLE→GRANT when any eligible request is present; GRANT→DATA always; DATA→IDLE always.
- Arbitration happens in IDLE, combinationally, over the eligible requesters.
  - Search starts at `(last_grant+1) mod N_CPU` and wraps.
  - The first eligible requester found is the winner `g`.
  - At the clock edge: register `g`, `last_grant<=g`, drive the GRANT outputs.
- Eligibility: `cpu_memory_valid[i]=1`, excluding `last_grant` in the first IDLE cycle after DATA (holdoff).
  - The holdoff covers a CPU that drops `memory_valid` late, up to two cycles after its ready pulse.
  - A CPU holding valid beyond that is treated as a new request.
- `cpu_memory_data`:
  - In DATA it equals `mem_data` combinationally.
  - At the end of DATA it is captured into `data_hold`.
  - In every other state it equals `data_hold`.
  - The value is therefore stable from the cycle after the ready pulse until the next DATA cycle.
- `mem_addr` keeps its last value outside GRANT. `mem_en=0` outside GRANT.
- Reset values: state IDLE; `last_grant=N_CPU-1`, so CPU 0 has first priority; `cpu_memory_ready=0`; `mem_en=0`; `mem_addr=0`; `data_hold=0`, so `cpu_memory_data=0`; holdoff inactive.
- Reset mid-operation:
  - All outputs clear asynchronously on `rst` falling.
  - An in-flight fetch is dropped with no ready-pulse replay.
  - After release, requesters still holding valid are served normally from priority 0.
- Widths: `last_grant` wraps modulo `N_CPU`. For non-power-of-2 `N_CPU`, indices ≥`N_CPU` never occur.

## Timing
- Request latency: valid seen in IDLE at edge E0 → GRANT in cycle E0–E1.
- Memory samples the address at E1. `mem_data` and the CPU data appear in E1–E2, at the same edge where ready drops.
- Throughput: one fetch per 3 cycles (GRANT, DATA, IDLE). The bus is never idle while an eligible request waits.
- Simultaneous requests: served strictly round-robin; worst-case wait is `3*(N_CPU-1)` cycles after becoming eligible.
- No combinational path from `cpu_memory_valid` to `cpu_memory_ready`, `mem_en` or `mem_addr`.
- Only combinational path: `mem_data`→`cpu_memory_data` (DATA state mux).

## Test plan
- **Single fetch:** CPU1 raises valid with addr 0x05A; memory model returns 0x4ABCD → `ready[1]` pulses one cycle together with `mem_en=1`, `mem_addr=0x05A`. `cpu_memory_data=0x4ABCD` on the next cycle and stays 0x4ABCD after `mem_data` changes to 0xFFFFF.
- **All request after reset:** CPUs 0–3 request addrs 0x010/0x020/0x030/0x040 simultaneously → grants in order 0,1,2,3, ready pulses exactly 3 cycles apart, each with matching `mem_addr` and data.
- **Fairness:** CPU0 re-requests continuously, CPU2 requests once → grant sequence 0,2,0,0… CPU2 is never starved beyond 3 cycles after its first eligibility.
- **Holdoff:** CPU3 holds valid 2 cycles after its ready pulse, then drops it → exactly one grant to CPU3 and no spurious `mem_en`.
- **Reset mid-fetch:** `rst` low during GRANT for CPU2 → `ready` and `mem_en` go 0 immediately. After release with CPU2 still valid → CPU2 re-granted 1 cycle later, and `cpu_memory_data=0` until that DATA cycle.
- **Wrap-around:** `last_grant=3`, CPUs 3 and 0 requesting → CPU0 granted first, then CPU3.
